multicycle_sequencer: RTL

Parametrised successor to the core's 3-state fetch/DEMW controller. It sequences the multicycle datapath over a variable-latency memory with a req/ready handshake. It splits execute, memory and writeback into separate states and adds trap entry for access faults, bus timeouts, illegal opcodes and external interrupts. Instruction-level ALU/mux decode stays in the decoder; this block owns sequencing and write enables only.

---
 rtl/multicycle_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH / EXEC / MEM / WB with trap entry
// for access faults, bus timeouts, illegal opcodes and external interrupts.
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TIMEOUT_W      = 8,
    parameter int unsigned RESET_DELAY    = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] ir_i,
    input  logic        mem_ready_i,
    input  logic        mem_error_i,
    input  logic        irq_i,
    input  logic        irq_enable_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        regfile_we_o,
    output logic        retire_o,
    output logic        trap_o,
    output logic [3:0]  trap_cause_o,
    output logic [2:0]  state_o
);

    localparam int unsigned DELAY_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [3:0] CAUSE_FETCH   = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_LOAD    = 4'd5;
    localparam logic [3:0] CAUSE_STORE   = 4'd7;
    localparam logic [3:0] CAUSE_IRQ     = 4'd11;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [DELAY_W-1:0]   delay_q;
    logic [TIMEOUT_W-1:0] tcnt_q;
    logic [3:0]           cause_q, cause_d;
    logic                 is_store_q;
    logic [6:0]           opcode;
    logic                 timed_out;
    logic                 irq_take;
    logic                 unused_ir_bits;

    assign opcode         = ir_i[6:0];
    assign unused_ir_bits = ^ir_i[31:7];
    assign irq_take       = irq_i & irq_enable_i;
    assign timed_out      = TO_EN && (tcnt_q == TIMEOUT_W'(TO_LAST)) && !mem_ready_i;
    assign state_o        = state_q;
    assign trap_cause_o   = cause_q;

    // State, counters and trap cause; timeout counter restarts on every new request
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= ST_RESET;
            delay_q    <= '0;
            tcnt_q     <= '0;
            cause_q    <= '0;
            is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == ST_RESET) begin
                delay_q <= delay_q + DELAY_W'(1);
            end
            if ((state_d == ST_FETCH || state_d == ST_MEM) && state_d != state_q) begin
                tcnt_q <= '0;
            end else if (mem_req_o && !mem_ready_i && tcnt_q != '1) begin
                tcnt_q <= tcnt_q + TIMEOUT_W'(1);
            end
            if (state_q == ST_EXEC) begin
                is_store_q <= (opcode == OPC_STORE);
            end
        end
    end

    // Next state and strobes; write enables only fire on completed requests
    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        regfile_we_o   = 1'b0;
        retire_o       = 1'b0;
        trap_o         = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (delay_q == DELAY_W'(RESET_DELAY - 1)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    if (mem_error_i) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_FETCH;
                    end else begin
                        ir_we_o = 1'b1;
                        state_d = ST_EXEC;
                    end
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_FETCH;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = ST_MEM;
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_SYSTEM: begin
                        pc_we_o      = 1'b1;
                        retire_o     = 1'b1;
                        regfile_we_o = 1'b1;
                    end
                    OPC_BRANCH, OPC_MISC_MEM: begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                    end
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = is_store_q;
                if ((mem_ready_i && mem_error_i) || timed_out) begin
                    state_d = ST_TRAP;
                    cause_d = is_store_q ? CAUSE_STORE : CAUSE_LOAD;
                end else if (mem_ready_i) begin
                    if (is_store_q) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                regfile_we_o = 1'b1;
                pc_we_o      = 1'b1;
                retire_o     = 1'b1;
            end
            ST_TRAP: begin
                trap_o  = 1'b1;
                pc_we_o = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_RESET;
        endcase

        // Instruction boundary: pending enabled interrupt preempts the next fetch
        if (retire_o) begin
            if (irq_take) begin
                state_d = ST_TRAP;
                cause_d = CAUSE_IRQ;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

endmodule
